uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- UART serial transmitter. Partner to the receive path: takes one byte per valid/ready handshake and shifts it out on UART_TXD as start bit, 8 data bits LSB-first, optional parity bit, then stop bit(s).
- Bit timing comes from the shared UART_CLK_EN tick, which runs at 16× the baud rate and is the same tick the receiver oversamples with.
- Sits between the speech-result/command logic and the board TX pin. Its output must loop back cleanly into the receiver.

Parameters:
- CLK_DIV_OVERSAMPLE, 16: UART_CLK_EN ticks per serial bit.
- PARITY_BIT, 0: 0 = no parity, 1 = even parity, 2 = odd parity.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- CLK  input  1  system clock; all logic is on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- UART_CLK_EN  input  1  one-CLK-wide baud tick at 16× baud.
- DATA_IN  input  8  byte to transmit; sampled on handshake.
- DATA_SEND  input  1  request (valid); the byte is accepted when DATA_SEND && DATA_RDY at a CLK edge.
- DATA_RDY  output  1  ready; high only in IDLE.
- UART_TXD  output  1  serial line; idles high.

Behaviour:
- Reset (asynchronous, RST=1):
  - UART_TXD=1, DATA_RDY=1, FSM=IDLE.
  - Shift register, bit index and tick counter all cleared.
  - Reset mid-frame aborts the frame immediately; the line returns high with no glitch to 0.
- Outputs: all are registered; no combinational path from inputs to outputs.
- States and transitions:
  - IDLE → START on handshake. DATA_IN is latched, DATA_RDY goes 0 and UART_TXD goes 0 on that same edge.
  - START → DATA after 16 ticks.
  - DATA → PARITY after 8 bits if PARITY_BIT≠0, otherwise DATA → STOP.
  - PARITY → STOP after 16 ticks.
  - STOP → IDLE after STOP_BITS×16 ticks.
- Bit timing:
  - The tick counter clears on every state or bit change.
  - A bit ends on the CLK edge where UART_CLK_EN=1 and the counter equals 15.
  - The next bit value appears on UART_TXD at that same edge.
  - Every bit therefore lasts exactly 16 UART_CLK_EN pulses, except the start bit, which may be up to one tick period longer depending on handshake phase.
  - CLK cycles with UART_CLK_EN=0 never advance the counter.
- DATA state:
  - UART_TXD = shift_reg[0]; the register shifts right at each bit boundary.
  - A 3-bit index counts 0..7.
- Parity:
  - Computed from the latched byte, never from the live DATA_IN.
  - Even: XOR of the 8 bits. Odd: inverted XOR.
  - PARITY_BIT values 3..7 are treated as 0.
- STOP: UART_TXD=1.
- DATA_RDY returns to 1 on the edge that enters IDLE. A DATA_SEND already high is accepted on the following edge, so the minimum inter-frame gap is 1 CLK of idle-high.
- DATA_SEND while busy is ignored; there is no queuing and no error flag.
- DATA_IN may change freely after the handshake edge.
- Frame length in ticks is 16 × (10 + (PARITY_BIT?1:0) + (STOP_BITS−1)).
  - Example: at 2 CLK per tick, an 8N1 frame is 320 CLK.

Test Plan:
- Reset then idle:
  - Stimulus: hold RST 5 CLK with DATA_SEND=0, then run 100 CLK.
  - Required: UART_TXD=1 and DATA_RDY=1 throughout; no transitions.
- 8N1 byte 0xA5:
  - Stimulus: CLK period 1 ns, UART_CLK_EN toggling every 1 ns; one-cycle DATA_SEND with DATA_IN=0xA5.
  - Required: UART_TXD sequence 0,1,0,1,0,0,1,0,1,1, each bit 32 ns wide after the start bit.
  - Required: DATA_RDY low for the whole frame, high again after the stop bit.
- Parity on 0xA5 (four ones):
  - PARITY_BIT=1 → parity bit 0.
  - PARITY_BIT=2 → parity bit 1.
  - In both cases the frame is 11 bits and the stop bit is 1.
- Back-to-back with loopback:
  - Stimulus: hold DATA_SEND=1 while presenting 0x3C then 0xFF; connect UART_TXD to UART_RX with matching PARITY_BIT.
  - Required: the second start bit begins 1 CLK after the first frame's stop bit ends.
  - Required: the receiver reports DATA_OUT=0x3C then 0xFF with DATA_VLD pulses and FRAME_ERROR=0.
- Ignored request while busy:
  - Stimulus: pulse DATA_SEND with 0x55 during the DATA state of 0x0F.
  - Required: the line carries only 0x0F; 0x55 is never sent.
- Reset mid-frame:
  - Stimulus: assert RST during data bit 3 of 0x00.
  - Required: UART_TXD=1 asynchronously and DATA_RDY=1.
  - Required: after release, a new 0x81 frame transmits correctly from its start bit.

Source files
------------

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake between the command logic and the UART transmitter.
// master drives DATA_IN/DATA_SEND, slave (uart_tx) returns DATA_RDY.
interface uart_tx_if;
  logic [7:0] DATA_IN;
  logic       DATA_SEND;
  logic       DATA_RDY;

  modport master (
    output DATA_IN,
    output DATA_SEND,
    input  DATA_RDY
  );

  modport slave (
    input  DATA_IN,
    input  DATA_SEND,
    output DATA_RDY
  );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: serial transmitter, start + 8 data LSB-first + opt. parity + stop.
// Ports: CLK, RST (async high), UART_CLK_EN (16x baud tick), tx (slave handshake), UART_TXD.
module uart_tx #(
  parameter int CLK_DIV_OVERSAMPLE = 16,
  parameter int PARITY_BIT         = 0,
  parameter int STOP_BITS          = 1
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      UART_CLK_EN,
  uart_tx_if.slave  tx,
  output logic      UART_TXD
);

  localparam int CW =
    (CLK_DIV_OVERSAMPLE > 1) ? $clog2(CLK_DIV_OVERSAMPLE) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV_OVERSAMPLE - 1);
  localparam int NSTOP = (STOP_BITS == 2) ? 2 : 1;
  // Unsupported parity codes fall back to no parity.
  localparam logic [1:0] PMODE =
    (PARITY_BIT == 1) ? 2'd1 :
    (PARITY_BIT == 2) ? 2'd2 : 2'd0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          par_q, par_d;
  logic          txd_q, txd_d;
  logic          rdy_q, rdy_d;
  logic          bit_end;

  assign bit_end = UART_CLK_EN && (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    txd_d   = txd_q;
    rdy_d   = rdy_q;

    // Counter only moves on ticks; it wraps at every bit boundary.
    if (state_q != IDLE && UART_CLK_EN) begin
      cnt_d = bit_end ? '0 : cnt_q + CW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (tx.DATA_SEND && rdy_q) begin
          state_d = START;
          shift_d = tx.DATA_IN;
          // Parity frozen from the accepted byte.
          par_d   = (^tx.DATA_IN) ^ (PMODE == 2'd2);
          idx_d   = '0;
          cnt_d   = '0;
          txd_d   = 1'b0;
          rdy_d   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
          txd_d   = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            idx_d = '0;
            if (PMODE != 2'd0) begin
              state_d = PARITY;
              txd_d   = par_q;
            end else begin
              state_d = STOP;
              txd_d   = 1'b1;
            end
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            txd_d   = shift_q[1];
            idx_d   = idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          idx_d   = '0;
          txd_d   = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (idx_q == 3'(NSTOP - 1)) begin
            state_d = IDLE;
            idx_d   = '0;
            rdy_d   = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
        rdy_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      rdy_q   <= rdy_d;
    end
  end

  assign tx.DATA_RDY = rdy_q;
  assign UART_TXD    = txd_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx across parity/stop variants.
// Four DUTs: 8N1, 8E1, 8O1, and parity code 5 (as none) with 2 stop bits.
`timescale 1ns/100ps
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] din [4];
  logic       snd [4];
  logic       txd [4];
  logic       rdy [4];
  int         n_chk  = 0;
  int         n_pass = 0;
  int         cyc    = 0;

  logic [11:0] cap [4];
  int          low [4];

  uart_tx_if if0 ();
  uart_tx_if if1 ();
  uart_tx_if if2 ();
  uart_tx_if if3 ();

  assign if0.DATA_IN   = din[0];
  assign if0.DATA_SEND = snd[0];
  assign rdy[0]        = if0.DATA_RDY;
  assign if1.DATA_IN   = din[1];
  assign if1.DATA_SEND = snd[1];
  assign rdy[1]        = if1.DATA_RDY;
  assign if2.DATA_IN   = din[2];
  assign if2.DATA_SEND = snd[2];
  assign rdy[2]        = if2.DATA_RDY;
  assign if3.DATA_IN   = din[3];
  assign if3.DATA_SEND = snd[3];
  assign rdy[3]        = if3.DATA_RDY;

  uart_tx #(.PARITY_BIT(0), .STOP_BITS(1)) u_n1 (
    .CLK(clk), .RST(rst), .UART_CLK_EN(en), .tx(if0), .UART_TXD(txd[0])
  );
  uart_tx #(.PARITY_BIT(1), .STOP_BITS(1)) u_e1 (
    .CLK(clk), .RST(rst), .UART_CLK_EN(en), .tx(if1), .UART_TXD(txd[1])
  );
  uart_tx #(.PARITY_BIT(2), .STOP_BITS(1)) u_o1 (
    .CLK(clk), .RST(rst), .UART_CLK_EN(en), .tx(if2), .UART_TXD(txd[2])
  );
  uart_tx #(.PARITY_BIT(5), .STOP_BITS(2)) u_n2 (
    .CLK(clk), .RST(rst), .UART_CLK_EN(en), .tx(if3), .UART_TXD(txd[3])
  );

  always #0.5 clk = ~clk;

  always @(posedge clk) begin
    en  <= ~en;
    cyc <= cyc + 1;
  end

  // Transition timestamps on the 8N1 line.
  logic mon = 1'b0;
  logic txd0_l = 1'b1;
  int   stamps [$];
  always @(negedge clk) begin
    if (mon && txd[0] !== txd0_l) stamps.push_back(cyc);
    txd0_l = txd[0];
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  function automatic logic get_txd(input int idx);
    return txd[idx];
  endfunction

  // Handshake aligned to a tick edge, then sample bit middles for 12 slots.
  task automatic frame(input logic [7:0] b, input int pulse_at);
    for (int i = 0; i < 4; i++) begin
      cap[i] = '0;
      low[i] = 0;
    end
    @(negedge clk);
    if (en !== 1'b1) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      snd[i] = 1'b1;
      din[i] = b;
    end
    for (int n = 0; n < 384; n++) begin
      @(negedge clk);
      if (n == 0) begin
        for (int i = 0; i < 4; i++) begin
          snd[i] = 1'b0;
          din[i] = 8'hFE;
        end
      end
      if (n == pulse_at) begin
        for (int i = 0; i < 4; i++) begin
          snd[i] = 1'b1;
          din[i] = 8'h55;
        end
      end
      if (pulse_at >= 0 && n == pulse_at + 1) begin
        for (int i = 0; i < 4; i++) snd[i] = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        if (rdy[i] === 1'b0) low[i]++;
        if (n % 32 == 16) cap[i][n/32] = txd[i];
      end
    end
  endtask

  // Reference receiver: mid-bit sampling of one frame.
  task automatic rx(input int idx, input int par,
                    output logic [7:0] b, output logic err);
    int g;
    b   = '0;
    err = 1'b0;
    g   = 0;
    while (get_txd(idx) !== 1'b0 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 2000) begin
      err = 1'b1;
      return;
    end
    repeat (16) @(negedge clk);
    if (get_txd(idx) !== 1'b0) err = 1'b1;
    for (int k = 0; k < 8; k++) begin
      repeat (32) @(negedge clk);
      b[k] = get_txd(idx);
    end
    if (par != 0) begin
      repeat (32) @(negedge clk);
      if (get_txd(idx) !== ((^b) ^ (par == 2))) err = 1'b1;
    end
    repeat (32) @(negedge clk);
    if (get_txd(idx) !== 1'b1) err = 1'b1;
  endtask

  // Holds DATA_SEND high across two frames; returns idle-high gap.
  task automatic feed(input int idx, output int gap);
    int g;
    din[idx] = 8'h3C;
    snd[idx] = 1'b1;
    for (g = 0; g < 100 && rdy[idx] !== 1'b0; g++) @(negedge clk);
    din[idx] = 8'hFF;
    for (g = 0; g < 1000 && rdy[idx] !== 1'b1; g++) @(negedge clk);
    gap = 0;
    while (get_txd(idx) === 1'b1 && gap < 10) begin
      gap++;
      @(negedge clk);
    end
    snd[idx] = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: timeout");
    $fatal(1);
  end

  initial begin
    int bad;
    int gap0, gap1;
    logic [7:0] b00, b01, b10, b11;
    logic e00, e01, e10, e11;
    int ed [7];

    ed = '{32, 32, 32, 32, 64, 32, 32};
    for (int i = 0; i < 4; i++) begin
      snd[i] = 1'b0;
      din[i] = 8'h00;
    end

    // Reset then idle
    repeat (5) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_txd%0d", i), 32'(txd[i]), 32'd1);
      chk($sformatf("rst_rdy%0d", i), 32'(rdy[i]), 32'd1);
    end
    rst = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++)
        if (txd[i] !== 1'b1 || rdy[i] !== 1'b1) bad++;
    end
    chk("idle_quiet", 32'(bad), 32'd0);

    // 0xA5 on all variants, with bit-edge timing on 8N1
    stamps.delete();
    mon = 1'b1;
    frame(8'hA5, -1);
    mon = 1'b0;
    chk("a5_n1",  32'(cap[0]), 32'({3'b111, 8'hA5, 1'b0}));
    chk("a5_e1",  32'(cap[1]), 32'({3'b110, 8'hA5, 1'b0}));
    chk("a5_o1",  32'(cap[2]), 32'({3'b111, 8'hA5, 1'b0}));
    chk("a5_n2",  32'(cap[3]), 32'({3'b111, 8'hA5, 1'b0}));
    chk("a5_len_n1", 32'(low[0]), 32'd320);
    chk("a5_len_e1", 32'(low[1]), 32'd352);
    chk("a5_len_o1", 32'(low[2]), 32'd352);
    chk("a5_len_n2", 32'(low[3]), 32'd352);
    chk("a5_edges", 32'(stamps.size()), 32'd8);
    if (stamps.size() == 8) begin
      for (int k = 0; k < 7; k++)
        chk($sformatf("a5_w%0d", k), 32'(stamps[k+1] - stamps[k]),
            32'(ed[k]));
    end

    // Back-to-back with loopback
    @(negedge clk);
    fork
      feed(0, gap0);
      feed(1, gap1);
      begin rx(0, 0, b00, e00); rx(0, 0, b01, e01); end
      begin rx(1, 1, b10, e10); rx(1, 1, b11, e11); end
    join
    chk("b2b_gap_n1", 32'(gap0), 32'd1);
    chk("b2b_gap_e1", 32'(gap1), 32'd1);
    chk("lb_n1_b0", 32'(b00), 32'h3C);
    chk("lb_n1_b1", 32'(b01), 32'hFF);
    chk("lb_e1_b0", 32'(b10), 32'h3C);
    chk("lb_e1_b1", 32'(b11), 32'hFF);
    chk("lb_err", 32'({e00, e01, e10, e11}), 32'd0);
    repeat (40) @(negedge clk);

    // Request while busy is dropped
    frame(8'h0F, 100);
    chk("busy_n1", 32'(cap[0]), 32'({3'b111, 8'h0F, 1'b0}));
    chk("busy_e1", 32'(cap[1]), 32'({3'b110, 8'h0F, 1'b0}));
    chk("busy_o1", 32'(cap[2]), 32'({3'b111, 8'h0F, 1'b0}));
    chk("busy_len", 32'(low[0]), 32'd320);

    // Reset during data bit 3 of 0x00
    @(negedge clk);
    if (en !== 1'b1) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      snd[i] = 1'b1;
      din[i] = 8'h00;
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) snd[i] = 1'b0;
    repeat (140) @(negedge clk);
    chk("mid_pre_txd", 32'(txd[0]), 32'd0);
    rst = 1'b1;
    #0.1;
    chk("mid_rst_txd", 32'(txd[0]), 32'd1);
    chk("mid_rst_rdy", 32'(rdy[0]), 32'd1);
    chk("mid_rst_txd_e1", 32'(txd[1]), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    frame(8'h81, -1);
    chk("post_n1", 32'(cap[0]), 32'({3'b111, 8'h81, 1'b0}));
    chk("post_e1", 32'(cap[1]), 32'({3'b110, 8'h81, 1'b0}));
    chk("post_o1", 32'(cap[2]), 32'({3'b111, 8'h81, 1'b0}));
    chk("post_len", 32'(low[0]), 32'd320);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
